// File: rtl/uart_frame_reader_pkg.sv
// rtl/uart_frame_reader_pkg.sv - shared frame defaults and reader FSM state encoding
package uart_frame_reader_pkg;

  localparam int          DEF_ADDR_W   = 16;
  localparam int          DEF_DATA_W   = 8;
  localparam int          DEF_HDR_LEN  = 16;
  localparam logic [7:0]  DEF_HDR_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_HWAIT = 3'd2,
    ST_RD    = 3'd3,
    ST_LAT   = 3'd4,
    ST_TWAIT = 3'd5,
    ST_DONE  = 3'd6
  } rd_state_t;

endpackage

// File: rtl/uart_frame_reader_if.sv
// rtl/uart_frame_reader_if.sv - frame RAM read port plus UART transmitter handshake
interface uart_frame_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_done;

  modport master (
    output rd_addr, rd_en, tx_data, tx_start,
    input  rd_data, tx_done
  );

  modport slave (
    input  rd_addr, rd_en, tx_data, tx_start,
    output rd_data, tx_done
  );

endinterface

// File: rtl/uart_frame_reader_start_edge_det.sv
// rtl/uart_frame_reader_start_edge_det.sv - single-flop rising-edge detector for the start level
module start_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/uart_frame_reader.sv
// rtl/uart_frame_reader.sv - streams one RAM frame into the UART transmitter, one byte in flight
// Build option READER_PREAMBLE_EN: prefix each frame with HDR_LEN copies of HDR_BYTE.
module uart_frame_reader
  import uart_frame_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = 1
`ifdef READER_PREAMBLE_EN
  ,
  parameter int                HDR_LEN  = DEF_HDR_LEN,
  parameter logic [DATA_W-1:0] HDR_BYTE = DATA_W'(DEF_HDR_BYTE)
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  uart_frame_reader_if.master  bus,
  output logic                 busy,
  output logic                 done
);

  rd_state_t         state;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              rd_en_q;
  logic              tx_start_q;
  logic [1:0]        lat_cnt;
  logic              start_rise;

`ifdef READER_PREAMBLE_EN
  localparam int HDR_W = $clog2(HDR_LEN + 1);
  logic [HDR_W-1:0] hdr_cnt;
`endif

  start_edge_det u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (start),
    .rise  (start_rise)
  );

  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      lat_cnt    <= '0;
`ifdef READER_PREAMBLE_EN
      hdr_cnt    <= '0;
`endif
    end else begin
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_rise) begin
            done      <= 1'b0;
            busy      <= 1'b1;
            rd_addr_q <= '0;
`ifdef READER_PREAMBLE_EN
            hdr_cnt   <= '0;
            state     <= ST_HDR;
`else
            state     <= ST_RD;
`endif
          end
        end
`ifdef READER_PREAMBLE_EN
        ST_HDR: begin
          tx_data_q  <= HDR_BYTE;
          tx_start_q <= 1'b1;
          state      <= ST_HWAIT;
        end
        ST_HWAIT: begin
          if (bus.tx_done) begin
            if (hdr_cnt == HDR_W'(HDR_LEN - 1)) begin
              state <= ST_RD;
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
              state   <= ST_HDR;
            end
          end
        end
`endif
        ST_RD: begin
          rd_en_q <= 1'b1;
          lat_cnt <= '0;
          state   <= ST_LAT;
        end
        // The strobe itself takes one cycle, so data is sampled RD_LATENCY cycles after it drops.
        ST_LAT: begin
          if (lat_cnt == 2'(RD_LATENCY)) begin
            tx_data_q  <= bus.rd_data;
            tx_start_q <= 1'b1;
            state      <= ST_TWAIT;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_TWAIT: begin
          if (bus.tx_done) begin
            if (rd_addr_q == '1) begin
              rd_addr_q <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
              state     <= ST_RD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_reader.sv
// tb/tb_uart_frame_reader.sv - scoreboard bench: RAM model, delayed tx_done responder, frame checks
module tb_uart_frame_reader;
  import uart_frame_reader_pkg::*;

  localparam int AW  = 4;
  localparam int NB  = 1 << AW;
  localparam int LAT = 3;
`ifdef READER_PREAMBLE_EN
  localparam int NH  = DEF_HDR_LEN;
`else
  localparam int NH  = 0;
`endif
  localparam int NF  = NH + NB;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  uart_frame_reader_if #(.ADDR_W(AW), .DATA_W(8)) bus ();

  uart_frame_reader #(.ADDR_W(AW), .DATA_W(8), .RD_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   n_tx     = 0;
  int   ref_cyc  = 0;
  int   spur_req = 0;
  int   spur_seen = 0;
  logic outst    = 1'b0;
  logic start_prev = 1'b0;
  logic busy_prev  = 1'b0;
  exp_t exp_q[$];
  logic [7:0] ram [NB];
  logic [7:0] pipe [LAT];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    pipe[0] <= bus.rd_en ? ram[bus.rd_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rd_data = pipe[LAT-1];

  // Transmitter model: tx_done 20 cycles after each tx_start, plus injected spurious pulses.
  initial begin
    int cnt;
    logic d;
    cnt = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      d = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) d = 1'b1;
      end
      if (spur_req != spur_seen) begin
        d = 1'b1;
        spur_seen = spur_req;
      end
      if (bus.tx_start) cnt = 20;
      bus.tx_done = d;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        outst = 1'b0;
      end else begin
        if (bus.tx_done && outst) begin
          outst   = 1'b0;
          ref_cyc = cyc;
        end
        if (start && !start_prev && !busy_prev) ref_cyc = cyc;
        if (bus.tx_start) begin
          n_tx++;
          check("single_outstanding", outst, 0);
          check("tx_start_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_data", bus.tx_data, e.data);
            check("tx_start_gap", cyc - ref_cyc, e.gap);
          end
          outst = 1'b1;
        end
      end
      start_prev = start;
      busy_prev  = busy;
    end
  end

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < NH; i++) begin
      e.data = DEF_HDR_BYTE;
      e.gap  = 1;
      exp_q.push_back(e);
    end
    for (int a = 0; a < NB; a++) begin
      e.data = ram[a];
      e.gap  = 2 + LAT;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 4000 && !done; k++) @(negedge clk);
    check(tag, done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_addr"}, bus.rd_addr, 0);
    check({tag, "_rd_en"}, bus.rd_en, 0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_tx_start"}, bus.tx_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int base;
    int stage;
    for (int i = 0; i < NB; i++) ram[i] = 8'(i + 8'h10);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Spurious tx_done while idle must not start anything.
    spur_req++;
    repeat (5) @(negedge clk);
    check("idle_spur_no_tx", n_tx, 0);
    check("idle_spur_busy", busy, 0);

    // Frame 1: plain read-out.
    base = n_tx;
    push_frame();
    start = 1'b1;
    @(negedge clk);
    check("f1_busy_after_edge", busy, 1);
    wait_done("f1_done");
    check("f1_count", n_tx - base, NF);
    check("f1_busy_end", busy, 0);
    check("f1_rd_addr_end", bus.rd_addr, 0);
    check("f1_queue_empty", exp_q.size(), 0);

    // Start held high through DONE: no restart.
    base = n_tx;
    repeat (60) @(negedge clk);
    check("hold_no_restart", n_tx - base, 0);
    check("hold_done_sticky", done, 1);

    // Frame 2: drop and raise start again.
    start = 1'b0;
    @(negedge clk);
    base = n_tx;
    push_frame();
    start = 1'b1;
    @(negedge clk);
    check("f2_done_cleared", done, 0);
    check("f2_busy", busy, 1);
    wait_done("f2_done");
    check("f2_count", n_tx - base, NF);

    // Frame 3: spurious tx_done in LAT, start re-edge during TWAIT.
    start = 1'b0;
    @(negedge clk);
    base = n_tx;
    push_frame();
    start = 1'b1;
    stage = 0;
    @(negedge clk);
    for (int k = 0; k < 4000 && !done; k++) begin
      if (stage == 0 && bus.rd_en && n_tx == base + NH + 2) begin
        spur_req++;
        stage = 1;
      end else if (stage == 1 && outst && n_tx == base + NH + 6) begin
        start = 1'b0;
        stage = 2;
      end else if (stage == 2) begin
        start = 1'b1;
        stage = 3;
      end
      @(negedge clk);
    end
    check("f3_done", done, 1);
    check("f3_stimulus_applied", stage, 3);
    check("f3_count", n_tx - base, NF);

    // Frame 4: reset just after the 5th byte is launched.
    start = 1'b0;
    @(negedge clk);
    base = n_tx;
    push_frame();
    start = 1'b1;
    for (int k = 0; k < 2000 && n_tx < base + 5; k++) @(negedge clk);
    check("f4_reached_5th", n_tx - base, 5);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    exp_q.delete();
    base = n_tx;
    repeat (80) @(negedge clk);
    check("post_reset_no_tx", n_tx - base, 0);
    check("post_reset_done", done, 0);
    check("post_reset_busy", busy, 0);

    // Frame 5: recovery after reset.
    base = n_tx;
    push_frame();
    start = 1'b1;
    wait_done("f5_done");
    check("f5_count", n_tx - base, NF);
    check("f5_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
